dmem_responder: RTL and testbench

- Responder (memory side) for the MEM-stage data-access interface. It serves one load or store at a time from a word-organised data array.
- Uses a valid/ready request channel and a valid/ready response channel, with a programmable number of wait states.
- Sits below the MEM stage. The `busy` output lets the hazard logic stall the pipeline while an access is outstanding.

---
 rtl/dmem_pkg.sv | 30 +++
 rtl/dmem_word_array.sv | 44 ++++
 rtl/dmem_responder.sv | 169 ++++++++++++++++
 tb/tb_dmem_responder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the MEM-stage data-memory responder:
//   - state_t      : responder FSM states (IDLE, WAIT, RESP)
//   - WORD_OFFSET  : number of byte-address bits below the word index
//   - DATA_W       : data word width
//   - REQ_ADDR_W   : width of the address field held in a latched request
//   - req_t        : one latched request (write, addr, wdata, be)
// ---------------------------------------------------------------------------
package dmem_pkg;

    localparam int WORD_OFFSET = 2;
    localparam int DATA_W      = 32;
    localparam int BE_W        = DATA_W / 8;
    localparam int REQ_ADDR_W  = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic                  write;
        logic [REQ_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     wdata;
        logic [BE_W-1:0]       be;
    } req_t;

endpackage

// File: rtl/dmem_word_array.sv
// ---------------------------------------------------------------------------
// dmem_word_array
// Word-organised storage with a synchronous byte-enable write and a
// combinational word read on the same address. Contents are not reset.
// Ports:
//   clk    in   clock
//   we     in   write strobe (qualified per byte by be)
//   be     in   byte enables, bit i covers data bits [8i+7:8i]
//   addr   in   word index
//   wdata  in   write data
//   rdata  out  word currently stored at addr
// ---------------------------------------------------------------------------
module dmem_word_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    // One independent byte lane per enable bit keeps every lane owned by a
    // single process.
    genvar gi;
    generate
        for (gi = 0; gi < BE_W; gi++) begin : g_lane
            logic [7:0] lane [DEPTH];

            always_ff @(posedge clk) begin
                if (we && be[gi]) begin
                    lane[addr] <= wdata[8*gi +: 8];
                end
            end

            assign rdata[8*gi +: 8] = lane[addr];
        end
    endgenerate

endmodule

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
// Memory-side responder for the MEM-stage data-access interface. Serves one
// load or store at a time with LATENCY wait states between accept and the
// access, then holds the response until it is consumed.
// Optional build macro: DMEM_ALIGN_CHECK_EN -- when defined, any request with
// addr[1:0] != 0 is answered with rsp_err=1 and no store takes place.
// Ports:
//   clk        in   clock
//   reset      in   asynchronous active-high reset
//   req_valid  in   request present
//   req_ready  out  responder can accept (high in IDLE)
//   req_write  in   1 = store, 0 = load
//   req_addr   in   byte address
//   req_wdata  in   store data
//   req_be     in   store byte enables
//   rsp_valid  out  response present (high in RESP)
//   rsp_ready  in   consumer accepts response
//   rsp_rdata  out  load data (0 for stores and errors)
//   rsp_err    out  out-of-range (or misaligned) access
//   busy       out  high whenever not IDLE
// ---------------------------------------------------------------------------
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int AW = $clog2(DEPTH);
    // Counter starts at LATENCY-1 so the access lands on the LATENCY-th edge
    // after accept.
    localparam logic [3:0] LAT_LOAD = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);
    localparam logic [ADDR_W-1:0] DEPTH_LIMIT = ADDR_W'(DEPTH);

    state_t              state_reg, state_next;
    logic [3:0]          count_reg;
    req_t                held_reg;
    logic [DATA_W-1:0]   rdata_reg;
    logic                err_reg;

    req_t                live_req;
    req_t                exec_req;
    logic                accept;
    logic                execute;
    logic [ADDR_W-1:0]   exec_addr;
    logic [ADDR_W-3:0]   word_index;
    logic                out_of_range;
    logic                misaligned;
    logic                access_err;
    logic                array_we;
    logic [DATA_W-1:0]   array_rdata;

    assign live_req = '{write: req_write,
                        addr:  REQ_ADDR_W'(req_addr),
                        wdata: req_wdata,
                        be:    req_be};

    // Next-state and access-strobe decode
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        execute    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (LATENCY == 0) begin
                        execute    = 1'b1;
                        state_next = RESP;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (count_reg == 4'd0) begin
                    execute    = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // With zero wait states the access executes on the accept edge itself,
    // before the request has been latched, so it must use the live inputs.
    always_comb begin
        exec_req = (state_reg == IDLE) ? live_req : held_reg;
    end

    assign exec_addr    = exec_req.addr[ADDR_W-1:0];
    assign word_index   = exec_addr[ADDR_W-1:WORD_OFFSET];
    assign out_of_range = ({2'b00, word_index} >= DEPTH_LIMIT);

`ifdef DMEM_ALIGN_CHECK_EN
    assign misaligned = |exec_addr[WORD_OFFSET-1:0];
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^exec_addr[WORD_OFFSET-1:0];
    assign misaligned       = 1'b0;
`endif

    assign access_err = out_of_range | misaligned;
    assign array_we   = execute & exec_req.write & ~access_err;

    dmem_word_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .we    (array_we),
        .be    (exec_req.be),
        .addr  (word_index[AW-1:0]),
        .wdata (exec_req.wdata),
        .rdata (array_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            count_reg <= 4'd0;
            held_reg  <= '0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                held_reg  <= live_req;
                count_reg <= LAT_LOAD;
            end else if (state_reg == WAIT && count_reg != 4'd0) begin
                count_reg <= count_reg - 4'd1;
            end
            // Response payload only changes at the access edge, so it stays
            // stable for as long as RESP is held.
            if (execute) begin
                err_reg   <= access_err;
                rdata_reg <= (access_err || exec_req.write) ? '0 : array_rdata;
            end
        end
    end

    assign req_ready = (state_reg == IDLE);
    assign rsp_valid = (state_reg == RESP);
    assign busy      = (state_reg != IDLE);
    assign rsp_rdata = rdata_reg;
    assign rsp_err   = err_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
// Directed plus randomized bench for dmem_responder (DEPTH=256, LATENCY=2).
// Expected responses come from a word-array reference model updated with
// plain byte-merge arithmetic. Honors DMEM_ALIGN_CHECK_EN the same way the
// design build does.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int DEPTH  = 256;
    localparam int LAT    = 2;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [3:0]        req_be;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] model_mem [DEPTH];

    dmem_responder #(
        .DEPTH   (DEPTH),
        .LATENCY (LAT),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference behaviour: word index = addr/4, error if beyond the array
    // (or misaligned when alignment checking is built in); stores merge the
    // enabled bytes, loads return the whole word.
    function automatic void model_access(input bit wr, input logic [31:0] addr,
                                         input logic [31:0] wdata, input logic [3:0] be,
                                         output logic [31:0] rd, output bit err);
        int unsigned idx;
        logic [1:0]  low;
        idx = addr / 4;
        low = addr[1:0];
        err = (idx >= DEPTH);
`ifdef DMEM_ALIGN_CHECK_EN
        if (low != 2'b00) err = 1'b1;
`else
        if (low != 2'b00) err = err;
`endif
        rd = 32'h0;
        if (!err) begin
            if (wr) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) model_mem[idx][8*b +: 8] = wdata[8*b +: 8];
            end else begin
                rd = model_mem[idx];
            end
        end
    endfunction

    task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input int hold, input bit early_ready);
        logic [31:0] exp_rd;
        bit          exp_err;
        int          cycles;
        model_access(wr, addr, wdata, be, exp_rd, exp_err);
        @(negedge clk);
        check("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        rsp_ready = early_ready;
        @(posedge clk);
        #1;
        // Request fields are don't-care after the accept edge.
        req_valid = 1'b0;
        req_write = 1'($urandom_range(0, 1));
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_be    = 4'($urandom_range(0, 15));
        check("busy_after_accept", busy, 1);
        cycles = 0;
        while (rsp_valid !== 1'b1 && cycles < 40) begin
            check("req_ready_wait", req_ready, 0);
            @(posedge clk);
            #1;
            cycles++;
        end
        check("latency_edges", cycles, LAT);
        check("rsp_rdata", rsp_rdata, exp_rd);
        check("rsp_err", rsp_err, exp_err);
        if (!early_ready) begin
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                check("hold_rsp_valid", rsp_valid, 1);
                check("hold_rsp_rdata", rsp_rdata, exp_rd);
                check("hold_rsp_err", rsp_err, exp_err);
                check("hold_req_ready", req_ready, 0);
            end
            rsp_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check("rsp_valid_drop", rsp_valid, 0);
        check("req_ready_back", req_ready, 1);
        check("busy_idle", busy, 0);
        if (!early_ready) rsp_ready = 1'b0;
        $display("[TB] %s addr=%h wdata=%h be=%b hold=%0d -> rdata=%h err=%0d (exp %h/%0d)",
                 wr ? "ST" : "LD", addr, wdata, be, hold, rsp_rdata, rsp_err, exp_rd, exp_err);
    endtask

    initial begin
        bit          wr;
        logic [31:0] addr;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        rsp_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_rdata", rsp_rdata, 0);
        check("reset_rsp_err", rsp_err, 0);
        check("reset_req_ready", req_ready, 1);
        check("reset_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;

        // Reset during WAIT drops a pending store.
        access(1'b1, 32'h10, 32'hCAFEF00D, 4'hF, 0, 1'b0);
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h10;
        req_wdata = 32'hDEADBEEF;
        req_be    = 4'hF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("abort_busy", busy, 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_rsp_valid", rsp_valid, 0);
        check("abort_busy_clear", busy, 0);
        check("abort_req_ready", req_ready, 1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("abort_rsp_valid_held", rsp_valid, 0);
        end
        @(negedge clk);
        reset = 1'b0;
        $display("[TB] reset asserted mid-WAIT for a store of deadbeef to 00000010");
        access(1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0);

        // Full-word store/load round trip.
        access(1'b1, 32'h20, 32'h12345678, 4'hF, 0, 1'b0);
        access(1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0);

        // Partial byte-enable merge.
        access(1'b1, 32'h24, 32'h11223344, 4'hF, 0, 1'b0);
        access(1'b1, 32'h24, 32'hAABBCCDD, 4'b0101, 0, 1'b0);
        access(1'b0, 32'h24, 32'h0, 4'hF, 0, 1'b0);

        // Out of range.
        access(1'b0, 32'h400, 32'h0, 4'h0, 0, 1'b0);
        access(1'b1, 32'h404, 32'h87654321, 4'hF, 0, 1'b0);

        // Response held for five cycles of backpressure.
        access(1'b0, 32'h20, 32'h0, 4'h0, 5, 1'b0);

        // Empty byte-enable store leaves the word alone.
        access(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 0, 1'b0);
        access(1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0);

        // Misaligned store: suppressed with the alignment check, else hits 0x20.
        access(1'b1, 32'h22, 32'h55667788, 4'hF, 0, 1'b0);
        access(1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0);

        // Fill the low words, then randomized traffic.
        for (int i = 0; i < 64; i++)
            access(1'b1, 32'(i * 4), $urandom, 4'hF, 0, 1'($urandom_range(0, 1)));
        for (int n = 0; n < 80; n++) begin
            wr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0)
                addr = 32'h400 + ($urandom & 32'h0FFF_FFFF);
            else
                addr = 32'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
            access(wr, addr, $urandom, 4'($urandom_range(0, 15)),
                   $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
